// File: rtl/interrupt_controller.sv
// Interrupt controller: synchronises and edge-detects NUM_SRC sources, masks them, and runs a one-at-a-time
// claim/ack/eoi handshake to the core. Define IRQ_ROUND_ROBIN_EN for rotating priority (default: lowest index wins).
module interrupt_controller #(
   parameter int NUM_SRC     = 8,
   parameter int ID_W        = $clog2(NUM_SRC),
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic               mask_wr,
   input  logic [NUM_SRC-1:0] mask_wdata,
   output logic [NUM_SRC-1:0] mask,
   output logic [NUM_SRC-1:0] pending,
   output logic               interrupt,
   output logic [ID_W-1:0]    irq_id,
   input  logic               irq_ack,
   input  logic               irq_eoi
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_REQ     = 2'd1;
   localparam logic [1:0] ST_SERVICE = 2'd2;

   logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
   logic [NUM_SRC-1:0] sync_d [SYNC_STAGES];
   logic [NUM_SRC-1:0] prev_q, prev_d;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] mask_q, mask_d;
   logic [NUM_SRC-1:0] pending_q, pending_d;
   logic [NUM_SRC-1:0] pending_clr;
   logic [NUM_SRC-1:0] candidates;
   logic [1:0]         state_q, state_d;
   logic               interrupt_q, interrupt_d;
   logic [ID_W-1:0]    irq_id_q, irq_id_d;
   logic [ID_W-1:0]    sel_id;

   // Synchroniser chain followed by one history register for rising-edge detection.
   always_comb begin
      sync_d[0] = irq_src;
      for (int s = 1; s < SYNC_STAGES; s++) begin
         sync_d[s] = sync_q[s-1];
      end
      prev_d = sync_q[SYNC_STAGES-1];
      rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
   end

   assign candidates = pending_q & mask_q;

`ifdef IRQ_ROUND_ROBIN_EN
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [NUM_SRC-1:0] rot;
   logic [ID_W-1:0]    rot_k;
   logic [ID_W:0]      rot_sum;

   // Rotate candidates so the pointer position becomes bit 0, pick the lowest, then undo the rotation.
   always_comb begin
      rot     = NUM_SRC'({candidates, candidates} >> ptr_q);
      rot_k   = '0;
      for (int k = NUM_SRC-1; k >= 0; k--) begin
         if (rot[k]) rot_k = ID_W'(k);
      end
      rot_sum = {1'b0, ptr_q} + {1'b0, rot_k};
      if (rot_sum >= (ID_W+1)'(NUM_SRC)) rot_sum = rot_sum - (ID_W+1)'(NUM_SRC);
      sel_id  = rot_sum[ID_W-1:0];
   end
`else
   always_comb begin
      sel_id = '0;
      for (int i = NUM_SRC-1; i >= 0; i--) begin
         if (candidates[i]) sel_id = ID_W'(i);
      end
   end
`endif

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch appears.
   always_comb begin
      state_d     = state_q;
      interrupt_d = interrupt_q;
      irq_id_d    = irq_id_q;
      pending_clr = '0;
`ifdef IRQ_ROUND_ROBIN_EN
      ptr_d       = ptr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            interrupt_d = 1'b0;
            if (|candidates) begin
               irq_id_d    = sel_id;
               interrupt_d = 1'b1;
               state_d     = ST_REQ;
            end
         end
         ST_REQ: begin
            if (irq_ack) begin
               pending_clr[irq_id_q] = 1'b1;
               interrupt_d           = 1'b0;
               state_d               = ST_SERVICE;
`ifdef IRQ_ROUND_ROBIN_EN
               ptr_d = (irq_id_q == ID_W'(NUM_SRC-1)) ? '0 : irq_id_q + ID_W'(1);
`endif
            end else if (!mask_q[irq_id_q]) begin
               // Masked while requesting: withdraw, but keep the pending flag for later.
               interrupt_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         ST_SERVICE: begin
            interrupt_d = 1'b0;
            if (irq_eoi) state_d = ST_IDLE;
         end
         default: begin
            interrupt_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
      mask_d    = mask_wr ? mask_wdata : mask_q;
      // A new edge in the same cycle as the ack clear keeps the flag set.
      pending_d = (pending_q & ~pending_clr) | rise;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= '0;
         end
         prev_q      <= '0;
         mask_q      <= '0;
         pending_q   <= '0;
         state_q     <= ST_IDLE;
         interrupt_q <= 1'b0;
         irq_id_q    <= '0;
`ifdef IRQ_ROUND_ROBIN_EN
         ptr_q       <= '0;
`endif
      end else begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_d[s];
         end
         prev_q      <= prev_d;
         mask_q      <= mask_d;
         pending_q   <= pending_d;
         state_q     <= state_d;
         interrupt_q <= interrupt_d;
         irq_id_q    <= irq_id_d;
`ifdef IRQ_ROUND_ROBIN_EN
         ptr_q       <= ptr_d;
`endif
      end
   end

   assign mask      = mask_q;
   assign pending   = pending_q;
   assign interrupt = interrupt_q;
   assign irq_id    = irq_id_q;

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Upstream of the Processor's single `interrupt` input.
- Collects NUM_SRC external interrupt sources, synchronises and edge-detects them, and latches pending flags.
- Applies a software-writable enable mask, selects one source by priority, and drives the Processor `interrupt` line.
- Runs a claim/acknowledge/end-of-interrupt handshake with the core so that only one interrupt is in service at a time.

Parameters:
- NUM_SRC, 8, number of interrupt sources (2..32).
- ID_W, $clog2(NUM_SRC), width of the source id.
- SYNC_STAGES, 2, synchroniser flops per source (>=2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- irq_src  input  NUM_SRC  raw asynchronous interrupt sources, rising-edge sensitive.
- mask_wr  input  1  write strobe for the enable mask.
- mask_wdata  input  NUM_SRC  new mask value (1 = enabled).
- mask  output  NUM_SRC  current enable mask.
- pending  output  NUM_SRC  latched pending flags.
- interrupt  output  1  interrupt request to Processor.interrupt.
- irq_id  output  ID_W  id of the source currently requested or in service.
- irq_ack  input  1  one-cycle claim pulse from the core.
- irq_eoi  input  1  one-cycle end-of-interrupt pulse from the core.

Behaviour:
- Reset (asynchronous):
  - mask=0, pending=0, interrupt=0, irq_id=0, all synchroniser and edge-history flops 0.
  - State goes to IDLE.
  - A source already high when reset releases is seen as a rising edge after synchronisation.
- Synchronisation and pending:
  - Each irq_src bit passes through SYNC_STAGES flops, then an edge register.
  - A rising edge (sync=1, prev=0) sets pending[i] on the same clock.
  - Pending is set on edges regardless of mask. Mask only gates selection.
- Latency:
  - A rising irq_src sampled at edge k appears in pending after edge k+SYNC_STAGES.
  - interrupt rises one edge later, provided the controller is IDLE and the source is enabled.
- Mask: on mask_wr, mask<=mask_wdata at the next edge. The new value is used for selection from the following cycle.
- Selection: candidates = pending & mask. The lowest index wins (fixed priority).
- FSM, registered outputs:
  - IDLE: interrupt=0. If candidates!=0, latch irq_id<=selected index and go to REQ.
  - REQ: interrupt=1.
    - irq_ack=1: clear pending[irq_id], interrupt<=0, go to SERVICE.
    - Else if mask[irq_id]==0 (source masked while requesting): interrupt<=0, go to IDLE, pending[irq_id] stays set.
    - irq_id is held stable throughout REQ. A higher-priority edge arriving during REQ does not preempt.
  - SERVICE: interrupt=0 and irq_id is held. Nested interrupts are not supported. irq_eoi=1 goes to IDLE.
    - Re-selection happens in IDLE on the next edge, so there is at least one idle cycle between services.
- Ignored handshakes: irq_ack outside REQ and irq_eoi outside SERVICE are ignored. irq_ack and irq_eoi together in REQ: ack is taken, eoi is ignored.
- Set/clear collision: a new edge on source irq_id in the same cycle as its ack clear leaves pending[irq_id]=1 (set wins). That edge is serviced later.
- Repeated edges: multiple edges on a source while it is pending collapse into one pending flag.
- Reset mid-operation: reset in REQ or SERVICE returns to IDLE immediately with interrupt=0 and all pending flags lost.

Optional Feature:
- Macro: IRQ_ROUND_ROBIN_EN.
- Defined: a rotating priority pointer (ID_W bits, reset 0) is kept. Selection takes the first candidate at or above the pointer, wrapping modulo NUM_SRC. On irq_ack the pointer becomes (irq_id+1) mod NUM_SRC.
- Undefined: fixed lowest-index priority. No pointer register is built.

Test Plan:
- Reset, mask_wr with 0x01, pulse irq_src[0] -> pending[0]=1 after SYNC_STAGES+1 edges, interrupt=1 one edge later, irq_id=0. irq_ack -> interrupt=0, pending=0x00. irq_eoi -> IDLE.
- mask=0xFF, raise irq_src[5] and irq_src[2] in the same cycle -> irq_id=2 first. After ack and eoi, irq_id=5 is requested. With IRQ_ROUND_ROBIN_EN and pointer=3, 5 is served before 2.
- mask=0x00, edge on irq_src[3] -> pending=0x08, interrupt stays 0. Write mask=0x08 -> interrupt=1 with irq_id=3 two edges after the write.
- In REQ with irq_id=4, write mask=0x00 -> interrupt drops next edge, state IDLE, pending[4] stays 1. Re-enable -> request reasserts with irq_id=4.
- In SERVICE, edge on irq_src[1] -> interrupt stays 0 until irq_eoi, then rises with irq_id=1. A stray irq_ack in IDLE or SERVICE has no effect.
- Assert reset while in REQ -> interrupt, pending, mask and irq_id all 0 within the same cycle, independent of clk.
